// File: rtl/sort4_controller_pkg.sv
// Shared definitions for the sort4 controller: state encodings, element width
// and counter-width helper.
package sort4_defs;

  localparam int unsigned ELEM_W = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Counter width for an N-entry burst, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned 4-bit magnitude comparator; exactly one output is high.
module comparator_4bit
  import sort4_defs::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic              greater,
  output logic              equal,
  output logic              less
);

  assign greater = (a > b);
  assign equal   = (a == b);
  assign less    = (a < b);

endmodule

// File: rtl/sort4_controller.sv
// Burst bubble-sorter: loads N nibbles, sorts in place with one shared
// comparator (one compare per clock), then drains them in ascending order.
module sort4_controller
  import sort4_defs::*;
#(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int unsigned   CW        = cnt_w(N);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

  state_e            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     pass_q, pass_d;
  logic              swapped_q, swapped_d;
  logic [ELEM_W-1:0] mem_q [N];
  logic [ELEM_W-1:0] mem_d [N];

  logic [CW-1:0]     j_nxt;
  logic [ELEM_W-1:0] cmp_a, cmp_b;
  logic              greater, equal, less;
  logic              any_swap;

  assign j_nxt    = j_q + CW'(1);
  assign cmp_a    = mem_q[j_q];
  assign cmp_b    = mem_q[j_nxt];
  assign any_swap = swapped_q | greater;

  comparator_4bit u_cmp (
    .a       (cmp_a),
    .b       (cmp_b),
    .greater (greater),
    .equal   (equal),
    .less    (less)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // Datapath registers: counters, swap flag and element storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      j_q       <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) mem_q[i] <= '0;
    end else begin
      idx_q     <= idx_d;
      j_q       <= j_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;
      for (int i = 0; i < int'(N); i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next-state, counter and swap-write logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    j_d       = j_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    for (int i = 0; i < int'(N); i++) mem_d[i] = mem_q[i];

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          mem_d[idx_q] = in_data;
          if (idx_q == LAST_IDX) begin
            state_d   = ST_SORT;
            idx_d     = '0;
            j_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      ST_SORT: begin
        // Swap only on strictly greater so equal keys keep their order.
        if (greater) begin
          mem_d[j_q]   = cmp_b;
          mem_d[j_nxt] = cmp_a;
        end
        if (j_q == (LAST_PASS - pass_q)) begin
          if (any_swap && (pass_q < LAST_PASS)) begin
            pass_d    = pass_q + CW'(1);
            j_d       = '0;
            swapped_d = 1'b0;
          end else begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end
        end else begin
          j_d       = j_nxt;
          swapped_d = any_swap;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Output decode from the registered state and storage.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_LOAD:  in_ready = 1'b1;
      ST_SORT:  busy     = 1'b1;
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem_q[idx_q];
        out_last  = (idx_q == LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert ($onehot({greater, equal, less}));
  end

endmodule

// File: tb/tb_sort4_controller.sv
// Scoreboard bench for sort4_controller: sorted bursts queued on load,
// popped and compared on drain.
module tb_sort4_controller;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] sb_q [$];

  sort4_controller #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one burst (optional gap before selected beats) and queue its sorted image.
  task automatic load_burst(input logic [3:0] v [N], input logic [N-1:0] gap, input logic hold_valid);
    logic [3:0] s [N];
    logic [3:0] t;
    for (int i = 0; i < N; i++) begin
      if (gap[i]) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      check("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v[i];
      @(negedge clk);
    end
    in_valid = hold_valid;
    in_data  = 4'hF;
    for (int i = 0; i < N; i++) s[i] = v[i];
    for (int i = 1; i < N; i++)
      for (int k = i; k > 0; k--)
        if (s[k-1] > s[k]) begin
          t = s[k]; s[k] = s[k-1]; s[k-1] = t;
        end
    for (int i = 0; i < N; i++) sb_q.push_back(s[i]);
  endtask

  task automatic wait_sort(input int exp_busy);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      if (busy) begin
        cnt++;
        check("in_ready_sort", in_ready, 0);
      end
      @(negedge clk);
    end
    check("drain_start", seen, 1);
    check("sort_cycles", cnt, exp_busy);
  endtask

  task automatic drain(input int stall_idx, input int stall_len);
    logic [3:0] e;
    for (int k = 0; k < N; k++) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 0, 1);
        e = 4'h0;
      end else begin
        e = sb_q[0];
      end
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, e);
          check("hold_last", out_last, (k == N-1));
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, e);
      check("out_last", out_last, (k == N-1));
      check("in_ready_drain", in_ready, 0);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("out_data_after", out_data, 0);
  endtask

  task automatic run_burst(input logic [3:0] v [N], input logic [N-1:0] gap, input logic hold_valid,
                           input int exp_busy, input int stall_idx, input int stall_len);
    load_burst(v, gap, hold_valid);
    wait_sort(exp_busy);
    drain(stall_idx, stall_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_burst('{4'd1, 4'd2, 4'd3, 4'd4},    4'b0000, 1'b0, 3, -1, 0);
    run_burst('{4'd15, 4'd14, 4'd13, 4'd0}, 4'b0000, 1'b0, 6, -1, 0);
    run_burst('{4'd5, 4'd5, 4'd5, 4'd5},    4'b0000, 1'b0, 3, -1, 0);
    run_burst('{4'd8, 4'd7, 4'd8, 4'd7},    4'b0000, 1'b0, 6, -1, 0);
    run_burst('{4'd3, 4'd1, 4'd2, 4'd0},    4'b0010, 1'b0, 6, 1, 3);

    // Reset in the second SORT cycle discards the burst.
    load_burst('{4'd9, 4'd3, 4'd6, 4'd1}, 4'b0000, 1'b0);
    check("midsort_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_idle", out_valid, 0);
    end
    run_burst('{4'd2, 4'd2, 4'd0, 4'd1},    4'b0000, 1'b0, 6, -1, 0);

    // in_valid held high through SORT and DRAIN must not load anything.
    run_burst('{4'd4, 4'd9, 4'd1, 4'd7},    4'b0000, 1'b1, 6, -1, 0);
    run_burst('{4'd6, 4'd0, 4'd12, 4'd3},   4'b0000, 1'b0, 6, -1, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
